mod_multiplier_barrett_pp_hs: RTL and testbench
===============================================

Name: mod_multiplier_barrett_pp_hs

Overview:
Parametrised, fully pipelined Barrett modular multiplier computing (iData0*iData1) mod iMod for DATA_WIDTH-bit operands. Next generation of the fixed 32-bit Barrett pipeline. Adds a valid/ready handshake with whole-pipe stall, and per-operation modulus/K/U carried down the pipe so the modulus may change every cycle. Adds tag passthrough and an input-range error flag. Sits in the NTT/polynomial datapath between operand fetch and butterfly write-back.

Parameters:
DATA_WIDTH, 32, operand/modulus width W (8..64)
TAG_WIDTH, 4, width of opaque per-operation tag
K_WIDTH, $clog2(DATA_WIDTH+1), width of iK (6 at W=32)

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  asynchronous reset, active-high
iValid  in  1  input operation valid
oReady  out  1  block can accept input this cycle
iData0  in  W  operand a, must satisfy a < iMod
iData1  in  W  operand b, must satisfy b < iMod
iMod  in  W  modulus m, must satisfy m >= 2
iK  in  K_WIDTH  bit length of m (1..W)
iU  in  W+2  Barrett constant floor(2^(2k)/m)
iTag  in  TAG_WIDTH  opaque tag returned with result
iClr  in  1  synchronous flush of all in-flight operations
oValid  out  1  result valid
iReady  in  1  downstream accepts result
oData  out  W  (a*b) mod m
oTag  out  TAG_WIDTH  tag of this result
oErr  out  1  operands out of range for this result

Behaviour:
- Reset (iRst high, async): all stage valids 0, oValid=0, oData=0, oTag=0, oErr=0. Data registers other than outputs need no reset. Reset mid-operation discards all in-flight work.
- Advance: adv = ~oValid | iReady; oReady = adv (combinational). All six stages shift together only when adv=1; otherwise every stage register holds.
- Input is accepted when iValid & oReady. A valid entering with iValid=0 propagates as a bubble. Bubbles occupy slots; no compaction.
- Latency: exactly 6 adv cycles from acceptance to oValid=1, i.e. 6 clocks with no stall. Throughput: 1 per clock with no stall.
- Per-stage sideband: k, u, m, tag, err and valid travel with the data. Input changes after acceptance never affect in-flight results.
- Stage 1: register a, b, m, k, u, tag. err = (a>=m) | (b>=m) | (m<2).
- Stage 2: p = a*b, 2W bits.
- Stage 3: q1 = p >> (k-1); q2 = q1*u.
- Stage 4: q3 = q2 >> (k+1); t = q3*m.
- Stage 5: r = p[W+1:0] - t[W+1:0], mod 2^(W+2).
- Stage 6: at most two conditional subtractions of m (r>=m -> r-m, then once more). Result lands in oData. If err, oData=0 and oErr=1.
- Result range: oData < m is guaranteed for in-range inputs with consistent k,u. k/u consistency is not checked; a mismatch gives undefined oData with oErr=0.
- Output holds: while oValid & ~iReady, oData/oTag/oErr are stable.
- iClr=1 at a clock edge clears all stage valids and oValid. Data is not cleared. An input offered in the same cycle is dropped: iClr wins over acceptance.
- iClr and stall together: the flush still occurs.
- Multipliers may be retimed inside their stage. Stage boundaries and latency are fixed.

Decomposition:
- Package mod_barrett_pkg: localparam BARRETT_LATENCY=6; function barrett_k_width(W); a struct carrying the per-stage sideband (valid, err, tag, k, u, m) parameterised via W-sized fields in the top module.
- One sub-module, mod_barrett_correct: stage-6 double conditional subtraction plus error zeroing, registered output, with hold on ~adv.

Test Plan:
- W=32, m=7681, k=13, u=8736, a=1467, b=2489, iReady=1 -> oData=2888 exactly 6 clocks after acceptance, oErr=0.
- m=4294967295, k=32, u=4294967297, a=b=4294967294 -> oData=1. Issue back-to-back right after the 7681 op -> outputs 2888 then 1 on consecutive cycles, tags preserved (3 then 5).
- 100 random streaming ops, random m/k/u per op computed by the bench model, iReady random at 50% -> every result matches the model in order. No result is lost or duplicated, and oData/oTag are stable while stalled.
- Pipe full with 6 ops, iReady=0 for 3 cycles -> oReady=0, oValid=1, outputs frozen. On iReady=1 the 6 results drain on consecutive cycles.
- a=7681 with m=7681 -> oErr=1, oData=0. m=1 -> oErr=1.
- Assert iClr with 4 ops in flight and iValid=1 -> no oValid for those ops. Next op accepted after clear appears 6 cycles later. iRst pulse mid-stream -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/mod_barrett_pkg.sv
// Shared constants and helpers for the pipelined Barrett modular multiplier.
package mod_barrett_pkg;

    // Acceptance-to-result distance in advancing clocks.
    localparam int BARRETT_LATENCY = 6;

    // Width needed to hold a bit length in the range 1..w.
    function automatic int barrett_k_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mod_barrett_correct.sv
// Final stage: brings the Barrett remainder from [0,3m) into [0,m), zeroes
// results of out-of-range operations and registers the outward handshake.
module mod_barrett_correct
    import mod_barrett_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iAdv,
    input  logic                  iClr,
    input  logic                  iValid,
    input  logic                  iErr,
    input  logic [TAG_WIDTH-1:0]  iTag,
    input  logic [DATA_WIDTH+1:0] iR,
    input  logic [DATA_WIDTH-1:0] iMod,
    output logic                  oValid,
    output logic [DATA_WIDTH-1:0] oData,
    output logic [TAG_WIDTH-1:0]  oTag,
    output logic                  oErr
);
    localparam int W = DATA_WIDTH;

    logic [W+1:0] w_m_ext;
    logic [W+1:0] w_r1;
    logic [W+1:0] w_r2;
    logic [W-1:0] w_res;

    // Two conditional subtractions cover the whole [0,3m) remainder range.
    always_comb begin
        w_m_ext = {2'b00, iMod};
        w_r1    = (iR >= w_m_ext) ? (iR - w_m_ext) : iR;
        w_r2    = (w_r1 >= w_m_ext) ? (w_r1 - w_m_ext) : w_r1;
        w_res   = iErr ? '0 : W'(w_r2);
    end

    // Output register: loads on advance, holds while stalled, flush drops valid.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid <= 1'b0;
            oData  <= '0;
            oTag   <= '0;
            oErr   <= 1'b0;
        end else begin
            if (iAdv) begin
                oValid <= iValid;
                oData  <= w_res;
                oTag   <= iTag;
                oErr   <= iErr;
            end
            if (iClr) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_multiplier_barrett_pp_hs.sv
// Six-stage Barrett modular multiplier with valid/ready handshake and
// whole-pipe stall. Modulus, k and u travel with each operation so the
// modulus may change every cycle.
module mod_multiplier_barrett_pp_hs
    import mod_barrett_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int K_WIDTH    = barrett_k_width(DATA_WIDTH)
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [DATA_WIDTH-1:0] iData0,
    input  logic [DATA_WIDTH-1:0] iData1,
    input  logic [DATA_WIDTH-1:0] iMod,
    input  logic [K_WIDTH-1:0]    iK,
    input  logic [DATA_WIDTH+1:0] iU,
    input  logic [TAG_WIDTH-1:0]  iTag,
    input  logic                  iClr,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [DATA_WIDTH-1:0] oData,
    output logic [TAG_WIDTH-1:0]  oTag,
    output logic                  oErr
);
    localparam int W  = DATA_WIDTH;
    localparam int W1 = DATA_WIDTH + 1;
    localparam int W2 = DATA_WIDTH + 2;
    localparam int NS = BARRETT_LATENCY - 1;  // stages ahead of the output stage

    typedef struct packed {
        logic                 vld;
        logic                 err;
        logic [TAG_WIDTH-1:0] tag;
        logic [K_WIDTH-1:0]   k;
        logic [W+1:0]         u;
        logic [W-1:0]         m;
    } sb_t;

    sb_t r_sb [1:NS];

    logic           w_adv;
    logic           w_err_in;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_p;
    logic [W+1:0]   r_p3;
    logic [W+1:0]   r_p4;
    logic [2*W+2:0] r_q2;
    logic [W+1:0]   r_t;
    logic [W+1:0]   r_r;
    logic [W:0]     w_q1;
    logic [W:0]     w_q3;

    assign w_adv  = ~oValid | iReady;
    assign oReady = w_adv;

    // Range check on the raw inputs; travels as a sideband flag.
    assign w_err_in = (iData0 >= iMod) | (iData1 >= iMod) | (iMod < W'(2));

    // With consistent k/u both quotients stay below 2^(k+1), so W+1 bits suffice.
    // k+1 is formed one bit wider so it cannot wrap at the top of the k range.
    assign w_q1 = W1'(r_p >> (r_sb[2].k - 1'b1));
    assign w_q3 = W1'(r_q2 >> ({1'b0, r_sb[3].k} + 1'b1));

    // Sideband shift register; flush clears only the valid bits.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int s = 1; s <= NS; s++) r_sb[s] <= '0;
        end else begin
            if (w_adv) begin
                r_sb[1] <= '{vld: iValid, err: w_err_in, tag: iTag,
                             k: iK, u: iU, m: iMod};
                for (int s = 2; s <= NS; s++) r_sb[s] <= r_sb[s-1];
            end
            if (iClr) begin
                for (int s = 1; s <= NS; s++) r_sb[s].vld <= 1'b0;
            end
        end
    end

    // Arithmetic stages 1-5; data needs no reset, it is qualified by the valids.
    // The remainder is below 3m < 2^(W+2), so p and t only matter mod 2^(W+2).
    always_ff @(posedge iClk) begin
        if (w_adv) begin
            r_a  <= iData0;
            r_b  <= iData1;
            r_p  <= r_a * r_b;
            r_p3 <= r_p[W+1:0];
            r_q2 <= w_q1 * r_sb[2].u;
            r_p4 <= r_p3;
            r_t  <= W2'(w_q3) * W2'(r_sb[3].m);
            r_r  <= r_p4 - r_t;
        end
    end

    mod_barrett_correct #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_correct (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAdv   (w_adv),
        .iClr   (iClr),
        .iValid (r_sb[NS].vld),
        .iErr   (r_sb[NS].err),
        .iTag   (r_sb[NS].tag),
        .iR     (r_r),
        .iMod   (r_sb[NS].m),
        .oValid (oValid),
        .oData  (oData),
        .oTag   (oTag),
        .oErr   (oErr)
    );

endmodule

// File: tb/tb_mod_multiplier_barrett_pp_hs.sv
// Bench for the handshake Barrett multiplier: directed cases plus a random
// stream, all checked against a plain-arithmetic reference kept here.
module tb_mod_multiplier_barrett_pp_hs;
    localparam int W  = 32;
    localparam int TW = 4;
    localparam int KW = 6;

    logic          iClk = 1'b0;
    logic          iRst, iValid, oReady, iClr, oValid, iReady, oErr;
    logic [W-1:0]  iData0, iData1, iMod, oData;
    logic [KW-1:0] iK;
    logic [W+1:0]  iU;
    logic [TW-1:0] iTag, oTag;

    int checks   = 0;
    int failures = 0;
    int adv_cnt  = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
    } exp_t;
    exp_t q[$];

    always #5 iClk = ~iClk;

    mod_multiplier_barrett_pp_hs dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iData0(iData0), .iData1(iData1), .iMod(iMod), .iK(iK), .iU(iU),
        .iTag(iTag), .iClr(iClr), .oValid(oValid), .iReady(iReady),
        .oData(oData), .oTag(oTag), .oErr(oErr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int calc_k(input logic [W-1:0] m);
        for (int i = W - 1; i >= 0; i--) if (m[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [63:0] calc_u(input logic [W-1:0] m, input int k);
        logic [127:0] n;
        n = 128'd1 << (2 * k);
        return 64'(n / {96'd0, m});
    endfunction

    function automatic logic [63:0] ref_mod(input logic [W-1:0] a, b, m);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p % {32'd0, m};
    endfunction

    task automatic set_op(input logic [W-1:0] a, b, m, input logic [TW-1:0] tag);
        int k;
        k      = calc_k(m);
        iData0 = a;
        iData1 = b;
        iMod   = m;
        iK     = KW'(k);
        iU     = 34'(calc_u(m, k));
        iTag   = tag;
    endtask

    task automatic rand_op();
        logic [W-1:0] m, a, b;
        case ($urandom_range(0, 3))
            0: m = $urandom_range(2, 255);
            1: m = $urandom_range(2, 65535);
            default: begin m = $urandom; if (m < 2) m = 2; end
        endcase
        a = $urandom % m;
        b = $urandom % m;
        if ($urandom_range(0, 9) == 0) a = m;
        if ($urandom_range(0, 19) == 0) begin m = 1; a = 0; b = 0; end
        set_op(a, b, m, TW'($urandom));
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Reference scoreboard: decisions sampled at the falling edge describe the
    // rising edge that follows. A result is due once 5 further advancing edges
    // have passed its acceptance edge (6 advancing edges in all).
    always @(negedge iClk) begin
        exp_t e;
        logic due;
        if (iRst) begin
            q.delete();
        end else begin
            due = (q.size() > 0) && (q[0].acc + 5 == adv_cnt);
            chk("oValid_model", 64'(oValid), 64'(due));
            if (oValid && q.size() > 0) begin
                chk("oData_model", 64'(oData), 64'(q[0].d));
                chk("oTag_model", 64'(oTag), 64'(q[0].tag));
                chk("oErr_model", 64'(oErr), 64'(q[0].err));
            end
            if (iClr) begin
                q.delete();
            end else begin
                if (oValid && iReady && q.size() > 0) void'(q.pop_front());
                if (oReady) adv_cnt++;
                if (iValid && oReady) begin
                    e.err = (iData0 >= iMod) || (iData1 >= iMod) || (iMod < 2);
                    e.d   = e.err ? '0 : W'(ref_mod(iData0, iData1, iMod));
                    e.tag = iTag;
                    e.acc = adv_cnt;
                    q.push_back(e);
                end
            end
        end
    end

    initial begin
        int n;
        int cyc;
        logic [W-1:0] held;
        iRst = 1'b1; iValid = 1'b0; iClr = 1'b0; iReady = 1'b1;
        set_op(0, 0, 2, 0);

        // Hand-computed values pinning the reference model
        chk("model_k_7681", 64'(calc_k(7681)), 64'd13);
        chk("model_u_7681", calc_u(7681, 13), 64'd8736);
        chk("model_u_big", calc_u(32'hFFFFFFFF, 32), 64'd4294967297);
        chk("model_ref_7681", ref_mod(1467, 2489, 7681), 64'd2888);

        #2;
        chk("rst_oValid", 64'(oValid), 64'd0);
        chk("rst_oData", 64'(oData), 64'd0);
        chk("rst_oTag", 64'(oTag), 64'd0);
        chk("rst_oErr", 64'(oErr), 64'd0);
        tick();
        iRst = 1'b0;
        tick();

        // Back-to-back directed pair, exact latency
        set_op(1467, 2489, 7681, 3); iValid = 1'b1;
        tick();
        set_op(32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 5);
        tick();
        iValid = 1'b0;
        repeat (3) tick();
        chk("lat_early", 64'(oValid), 64'd0);
        tick();
        chk("d0_valid", 64'(oValid), 64'd1);
        chk("d0_data", 64'(oData), 64'd2888);
        chk("d0_tag", 64'(oTag), 64'd3);
        chk("d0_err", 64'(oErr), 64'd0);
        tick();
        chk("d1_valid", 64'(oValid), 64'd1);
        chk("d1_data", 64'(oData), 64'd1);
        chk("d1_tag", 64'(oTag), 64'd5);
        tick();
        chk("d_after", 64'(oValid), 64'd0);

        // Fill pipe with 6 ops while downstream is stalled
        iReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_op(W'(100 + i), W'(200 + i), 7681, TW'(i)); iValid = 1'b1;
            tick();
        end
        iValid = 1'b0;
        held = oData;
        chk("full_data", 64'(held), ref_mod(100, 200, 7681));
        for (int i = 0; i < 3; i++) begin
            chk("stall_oReady", 64'(oReady), 64'd0);
            chk("stall_oValid", 64'(oValid), 64'd1);
            chk("stall_hold", 64'(oData), 64'(held));
            tick();
        end
        iReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_valid", 64'(oValid), 64'd1);
            chk("drain_tag", 64'(oTag), 64'(i));
            tick();
        end
        chk("drain_done", 64'(oValid), 64'd0);

        // Range errors
        set_op(7681, 5, 7681, 9); iValid = 1'b1;
        tick();
        set_op(0, 0, 1, 10);
        tick();
        iValid = 1'b0;
        repeat (4) tick();
        chk("err_a_flag", 64'(oErr), 64'd1);
        chk("err_a_data", 64'(oData), 64'd0);
        tick();
        chk("err_m1_flag", 64'(oErr), 64'd1);
        tick();

        // Flush with 4 ops in flight and a competing input
        for (int i = 0; i < 4; i++) begin
            set_op(W'(i + 1), 7, 7681, TW'(i)); iValid = 1'b1;
            tick();
        end
        set_op(11, 12, 7681, 15); iClr = 1'b1;
        tick();
        iClr = 1'b0; iValid = 1'b0;
        n = 0;
        repeat (8) begin
            if (oValid) n++;
            tick();
        end
        chk("clr_no_valid", 64'(n), 64'd0);
        set_op(1467, 2489, 7681, 6); iValid = 1'b1;
        tick();
        iValid = 1'b0;
        repeat (4) tick();
        chk("clr_next_early", 64'(oValid), 64'd0);
        tick();
        chk("clr_next_valid", 64'(oValid), 64'd1);
        chk("clr_next_data", 64'(oData), 64'd2888);
        tick();

        // Async reset mid-stream
        for (int i = 0; i < 6; i++) begin
            set_op(W'(i + 3), 9, 7681, TW'(i)); iValid = 1'b1;
            tick();
        end
        iValid = 1'b0;
        #2 iRst = 1'b1;
        #1;
        chk("arst_oValid", 64'(oValid), 64'd0);
        chk("arst_oData", 64'(oData), 64'd0);
        chk("arst_oTag", 64'(oTag), 64'd0);
        chk("arst_oReady", 64'(oReady), 64'd1);
        tick();
        iRst = 1'b0;
        repeat (8) tick();

        // Random streaming with random backpressure
        n = 0;
        cyc = 0;
        while (n < 100 && cyc < 5000) begin
            cyc++;
            iReady = 1'($urandom_range(0, 1));
            iValid = ($urandom_range(0, 9) < 7);
            rand_op();
            #1;
            if (iValid && oReady) n++;
            @(posedge iClk);
            #1;
        end
        chk("rand_accepted", 64'(n), 64'd100);
        iValid = 1'b0;
        iReady = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            cyc++;
            tick();
        end
        chk("rand_drained", 64'(q.size()), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
